// File: rtl/sha1_chain_engine_pkg.sv
// Shared types, constants and arithmetic helpers for the chained SHA-1 engine.
package sha1_chain_engine_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ROUND,
      ST_FINAL,
      ST_HOLD
   } state_t;

   localparam logic [31:0] H0 = 32'h67452301;
   localparam logic [31:0] H1 = 32'hEFCDAB89;
   localparam logic [31:0] H2 = 32'h98BADCFE;
   localparam logic [31:0] H3 = 32'h10325476;
   localparam logic [31:0] H4 = 32'hC3D2E1F0;
   localparam logic [159:0] IV = {H0, H1, H2, H3, H4};

   localparam logic [31:0] K0 = 32'h5A827999;
   localparam logic [31:0] K1 = 32'h6ED9EBA1;
   localparam logic [31:0] K2 = 32'h8F1BBCDC;
   localparam logic [31:0] K3 = 32'hCA62C1D6;

   function automatic logic [31:0] rotl32(input logic [31:0] x, input int unsigned n);
      return (x << n) | (x >> (32 - n));
   endfunction

   function automatic logic [31:0] f_sel(input logic [6:0] t, input logic [31:0] b,
                                         input logic [31:0] c, input logic [31:0] d);
      if (t < 7'd20)      return (b & c) | (~b & d);
      else if (t < 7'd40) return b ^ c ^ d;
      else if (t < 7'd60) return (b & c) | (b & d) | (c & d);
      else                return b ^ c ^ d;
   endfunction

   function automatic logic [31:0] k_sel(input logic [6:0] t);
      if (t < 7'd20)      return K0;
      else if (t < 7'd40) return K1;
      else if (t < 7'd60) return K2;
      else                return K3;
   endfunction

   function automatic logic [31:0] w_sched(input logic [31:0] w3, input logic [31:0] w8,
                                           input logic [31:0] w14, input logic [31:0] w16);
      return rotl32(w3 ^ w8 ^ w14 ^ w16, 1);
   endfunction

   // Word-wise mod 2^32 addition of two {h0..h4} vectors.
   function automatic logic [159:0] add5(input logic [159:0] x, input logic [159:0] y);
      logic [159:0] r;
      for (int i = 0; i < 5; i++) r[32*i +: 32] = x[32*i +: 32] + y[32*i +: 32];
      return r;
   endfunction

endpackage

// File: rtl/sha1_chain_engine_round.sv
// One combinational SHA-1 round on the packed working state {a,b,c,d,e}.
module sha1_chain_engine_round
   import sha1_chain_engine_pkg::*;
(
   input  logic [6:0]   t,
   input  logic [31:0]  w,
   input  logic [159:0] state_in,
   output logic [159:0] state_out
);

   logic [31:0] a, b, c, d, e;
   logic [31:0] tmp;

   assign {a, b, c, d, e} = state_in;
   assign tmp = rotl32(a, 5) + f_sel(t, b, c, d) + e + k_sel(t) + w;
   assign state_out = {tmp, a, rotl32(b, 30), c, d};

endmodule

// File: rtl/sha1_chain_engine.sv
// Multi-block SHA-1 engine: chains the intermediate hash across the blocks of a
// message and holds the final digest until the consumer takes it.
//
// state | meaning
// IDLE  | in_ready=1, waiting for a chunk; loads W window and working state
// ROUND | ROUNDS_PER_CYCLE rounds per clock over a sliding 16-word W window
// FINAL | folds working state into the chain; last block -> HOLD, else -> IDLE
// HOLD  | publishes digest, then waits for out_ready; chain returns to IV
module sha1_chain_engine
   import sha1_chain_engine_pkg::*;
#(
   parameter int ROUNDS_PER_CYCLE = 4,
   parameter int TAG_W            = 8
) (
   input  logic             clk,
   input  logic             areset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_first,
   input  logic             in_last,
   input  logic [TAG_W-1:0] in_tag,
   input  logic [511:0]     chunk,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [TAG_W-1:0] out_tag,
   output logic [159:0]     digest,
   output logic [7:0]       out_nblk
);

   localparam int RPC = ROUNDS_PER_CYCLE;
   localparam logic [6:0] T_STEP = 7'(RPC);
   localparam logic [6:0] T_LAST = 7'(80 - RPC);

   if ((RPC < 1) || (RPC > 20) || ((80 % RPC) != 0)) begin : g_bad_rpc
      $error("ROUNDS_PER_CYCLE must be one of 1,2,4,5,8,10,16,20");
   end

   state_t           state;
   logic [6:0]       t;
   logic [159:0]     st;
   logic [159:0]     chain;
   logic [31:0]      w [16];
   logic             last_blk;
   logic [TAG_W-1:0] tag_q;
   logic [7:0]       nblk;

   logic [31:0]      w_rnd [RPC];
   logic [31:0]      w_nxt [16];
   logic [159:0]     rnd_out;

   // Extend the window by RPC scheduled words; round j consumes wx[j].
   always_comb begin : p_wsched
      logic [31:0] wx [16+RPC];
      for (int i = 0; i < 16; i++) wx[i] = w[i];
      for (int i = 16; i < 16 + RPC; i++) wx[i] = w_sched(wx[i-3], wx[i-8], wx[i-14], wx[i-16]);
      for (int j = 0; j < RPC; j++) w_rnd[j] = wx[j];
      for (int i = 0; i < 16; i++) w_nxt[i] = wx[i+RPC];
   end

   for (genvar j = 0; j < RPC; j++) begin : g_rnd
      logic [159:0] st_in;
      logic [159:0] st_out;
      if (j == 0) begin : g_head
         assign st_in = st;
      end else begin : g_link
         assign st_in = g_rnd[j-1].st_out;
      end
      sha1_chain_engine_round u_round (
         .t         (t + 7'(j)),
         .w         (w_rnd[j]),
         .state_in  (st_in),
         .state_out (st_out)
      );
   end

   assign rnd_out = g_rnd[RPC-1].st_out;

   always_ff @(posedge clk or negedge areset) begin
      if (!areset) begin
         state     <= ST_IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         digest    <= '0;
         out_tag   <= '0;
         out_nblk  <= '0;
         chain     <= IV;
         st        <= '0;
         t         <= '0;
         last_blk  <= 1'b0;
         tag_q     <= '0;
         nblk      <= '0;
         for (int i = 0; i < 16; i++) w[i] <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid && in_ready) begin
                  for (int i = 0; i < 16; i++) w[i] <= chunk[511-32*i -: 32];
                  // A first block always restarts from IV, abandoning any open chain.
                  if (in_first) begin
                     st    <= IV;
                     chain <= IV;
                     tag_q <= in_tag;
                     nblk  <= 8'd1;
                  end else begin
                     st <= chain;
                     if (nblk != 8'hFF) nblk <= nblk + 8'd1;
                  end
                  last_blk <= in_last;
                  t        <= '0;
                  in_ready <= 1'b0;
                  state    <= ST_ROUND;
               end
            end
            ST_ROUND: begin
               st <= rnd_out;
               for (int i = 0; i < 16; i++) w[i] <= w_nxt[i];
               t <= t + T_STEP;
               if (t == T_LAST) state <= ST_FINAL;
            end
            ST_FINAL: begin
               chain <= add5(chain, st);
               if (last_blk) begin
                  state <= ST_HOLD;
               end else begin
                  in_ready <= 1'b1;
                  state    <= ST_IDLE;
               end
            end
            ST_HOLD: begin
               if (!out_valid) begin
                  digest    <= chain;
                  out_tag   <= tag_q;
                  out_nblk  <= nblk;
                  out_valid <= 1'b1;
               end else if (out_ready) begin
                  out_valid <= 1'b0;
                  chain     <= IV;
                  nblk      <= '0;
                  in_ready  <= 1'b1;
                  state     <= ST_IDLE;
               end
            end
            default: begin
               in_ready <= 1'b1;
               state    <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sha1_chain_engine.sv
// Self-checking bench for sha1_chain_engine: known-answer table, framing corner
// cases, async reset, and random multi-block messages against a SHA-1 model.
module tb_sha1_chain_engine;

   localparam int RPC  = 4;
   localparam int NCYC = 80 / RPC;

   localparam logic [159:0] IV = 160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0;
   localparam logic [511:0] CK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
   localparam logic [511:0] CK_EMPTY = {32'h80000000, 480'h0};
   localparam logic [511:0] CK_B1 = 512'h61626364_62636465_63646566_64656667_65666768_66676869_6768696a_68696a6b_696a6b6c_6a6b6c6d_6b6c6d6e_6c6d6e6f_6d6e6f70_6e6f7071_80000000_00000000;
   localparam logic [511:0] CK_B2 = {480'h0, 32'h000001c0};
   localparam logic [159:0] D_ABC   = 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d;
   localparam logic [159:0] D_EMPTY = 160'hda39a3ee_5e6b4b0d_3255bfef_95601890_afd80709;
   localparam logic [159:0] D_TWO   = 160'h84983e44_1c3bd26e_baae4aa1_f95129e5_e54670f1;

   logic         clk = 1'b0;
   logic         areset = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic         in_first = 1'b0;
   logic         in_last = 1'b0;
   logic [7:0]   in_tag = '0;
   logic [511:0] chunk = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [7:0]   out_tag;
   logic [159:0] digest;
   logic [7:0]   out_nblk;

   int total = 0;
   int bad = 0;

   typedef struct {
      logic         first;
      logic         last;
      logic [7:0]   tag;
      logic [511:0] chunk;
      int           hold;
      logic [159:0] exp_dig;
      logic [7:0]   exp_tag;
      logic [7:0]   exp_nblk;
   } vec_t;

   vec_t tbl [4];

   sha1_chain_engine #(.ROUNDS_PER_CYCLE(RPC), .TAG_W(8)) dut (
      .clk       (clk),
      .areset    (areset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_first  (in_first),
      .in_last   (in_last),
      .in_tag    (in_tag),
      .chunk     (chunk),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_tag   (out_tag),
      .digest    (digest),
      .out_nblk  (out_nblk)
   );

   always #5 clk = ~clk;

   // Textbook SHA-1 compression of one block onto hash h.
   function automatic logic [159:0] ref_block(input logic [159:0] h, input logic [511:0] blk);
      logic [31:0] w [80];
      logic [31:0] a, b, c, d, e, f, k, tmp;
      for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
      for (int i = 16; i < 80; i++) begin
         tmp  = w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16];
         w[i] = {tmp[30:0], tmp[31]};
      end
      {a, b, c, d, e} = h;
      for (int i = 0; i < 80; i++) begin
         if (i < 20)      begin f = (b & c) | (~b & d);          k = 32'h5A827999; end
         else if (i < 40) begin f = b ^ c ^ d;                   k = 32'h6ED9EBA1; end
         else if (i < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8F1BBCDC; end
         else             begin f = b ^ c ^ d;                   k = 32'hCA62C1D6; end
         tmp = {a[26:0], a[31:27]} + f + e + k + w[i];
         e = d; d = c; c = {b[1:0], b[31:2]}; b = a; a = tmp;
      end
      return {h[159:128] + a, h[127:96] + b, h[95:64] + c, h[63:32] + d, h[31:0] + e};
   endfunction

   function automatic logic [511:0] rnd_chunk();
      logic [511:0] r;
      for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
      return r;
   endfunction

   task automatic chk_i(input string nm, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, got, exp);
      end
   endtask

   task automatic chk_d(input string nm, input logic [159:0] got, input logic [159:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   task automatic wait_for(input bit want_out, input string nm, output int lat);
      lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
      end while (!(want_out ? out_valid : in_ready) && lat < 400);
      if (!(want_out ? out_valid : in_ready)) begin
         total++; bad++;
         $display("FAIL %s: timeout after %0d cycles", nm, lat);
      end
   endtask

   task automatic send(input logic f, input logic l, input logic [7:0] tg,
                       input logic [511:0] ck, input string nm);
      int n;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         total++; bad++;
         $display("FAIL %s: in_ready got 0 expected 1", nm);
      end
      in_valid = 1'b1; in_first = f; in_last = l; in_tag = tg; chunk = ck;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic run_blk(input vec_t v, input string nm);
      int lat;
      logic [159:0] d0;
      bit stable;
      out_ready = 1'b0;
      send(v.first, v.last, v.tag, v.chunk, nm);
      chk_i({nm, "_busy"}, int'(in_ready), 0);
      if (v.last) begin
         wait_for(1'b1, nm, lat);
         chk_i({nm, "_lat"}, lat, NCYC + 2);
         chk_d({nm, "_digest"}, digest, v.exp_dig);
         chk_i({nm, "_tag"}, int'(out_tag), int'(v.exp_tag));
         chk_i({nm, "_nblk"}, int'(out_nblk), int'(v.exp_nblk));
         d0 = digest;
         stable = 1'b1;
         in_valid = 1'b1;  // a chunk offered while the digest is blocked must wait
         repeat (v.hold) begin
            @(negedge clk);
            if (!out_valid || digest !== d0 || in_ready) stable = 1'b0;
         end
         chk_i({nm, "_hold"}, int'(stable), 1);
         @(negedge clk);
         out_ready = 1'b1;
         @(posedge clk); #1;
         out_ready = 1'b0;
         in_valid = 1'b0;
         chk_i({nm, "_drain_ov"}, int'(out_valid), 0);
         chk_i({nm, "_drain_ir"}, int'(in_ready), 1);
      end else begin
         wait_for(1'b0, nm, lat);
         chk_i({nm, "_ii"}, lat, NCYC + 1);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v;
      logic [159:0] h;
      logic [7:0] tg;
      int nb;

      tbl[0] = '{1'b1, 1'b1, 8'hA1, CK_ABC,   10, D_ABC,   8'hA1, 8'd1};
      tbl[1] = '{1'b1, 1'b1, 8'hB2, CK_EMPTY, 0,  D_EMPTY, 8'hB2, 8'd1};
      tbl[2] = '{1'b1, 1'b0, 8'h5A, CK_B1,    0,  '0,      8'h5A, 8'd1};
      tbl[3] = '{1'b0, 1'b1, 8'hFF, CK_B2,    2,  D_TWO,   8'h5A, 8'd2};

      repeat (2) @(negedge clk);
      chk_i("rst_in_ready", int'(in_ready), 1);
      chk_i("rst_out_valid", int'(out_valid), 0);
      chk_d("rst_digest", digest, '0);
      chk_i("rst_out_tag", int'(out_tag), 0);
      chk_i("rst_out_nblk", int'(out_nblk), 0);
      areset = 1'b1;

      // continuation with no open message after reset: IV chain, tag still 0
      v = '{1'b0, 1'b1, 8'h77, CK_ABC, 1, D_ABC, 8'h00, 8'd1};
      run_blk(v, "orphan_rst");

      for (int i = 0; i < 4; i++) run_blk(tbl[i], $sformatf("tbl%0d", i));

      // continuation after a digest: IV chain, last sampled tag
      v = '{1'b0, 1'b1, 8'hEE, CK_ABC, 0, D_ABC, 8'h5A, 8'd1};
      run_blk(v, "orphan_done");

      // restart mid-message abandons the open chain
      v = '{1'b1, 1'b0, 8'h11, CK_B1, 0, '0, 8'h11, 8'd1};
      run_blk(v, "restart_b1");
      v = '{1'b1, 1'b1, 8'h22, CK_ABC, 3, D_ABC, 8'h22, 8'd1};
      run_blk(v, "restart_abc");

      // async reset while rounds are in flight
      send(1'b1, 1'b1, 8'h33, CK_ABC, "areset_send");
      repeat (3) @(posedge clk);
      #2 areset = 1'b0;
      #1;
      chk_i("areset_out_valid", int'(out_valid), 0);
      chk_i("areset_in_ready", int'(in_ready), 1);
      chk_d("areset_digest", digest, '0);
      @(negedge clk);
      areset = 1'b1;
      v = '{1'b1, 1'b1, 8'h44, CK_ABC, 1, D_ABC, 8'h44, 8'd1};
      run_blk(v, "areset_rerun");

      // random multi-block messages against the model
      for (int m = 0; m < 8; m++) begin
         nb = int'($urandom_range(1, 3));
         h  = IV;
         tg = 8'($urandom);
         for (int b = 0; b < nb; b++) begin
            v.chunk    = rnd_chunk();
            v.first    = (b == 0);
            v.last     = (b == nb - 1);
            v.tag      = v.first ? tg : 8'($urandom);
            h          = ref_block(h, v.chunk);
            v.exp_dig  = h;
            v.exp_tag  = tg;
            v.exp_nblk = 8'(b + 1);
            v.hold     = int'($urandom_range(0, 4));
            run_blk(v, $sformatf("rand%0d_b%0d", m, b));
         end
      end

      // 256-block message: block count saturates at 255
      h = IV;
      for (int b = 0; b < 256; b++) begin
         v.chunk    = rnd_chunk();
         v.first    = (b == 0);
         v.last     = (b == 255);
         v.tag      = 8'hC3;
         h          = ref_block(h, v.chunk);
         v.exp_dig  = h;
         v.exp_tag  = 8'hC3;
         v.exp_nblk = 8'd255;
         v.hold     = 1;
         run_blk(v, "sat");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
